// File: rtl/antares_muldiv_ctrl.sv
// MDU control: owns HI/LO, runs a 2-cycle pipelined 32x32 multiply and
// sequences the external multi-cycle divider (start pulse, busy wait, writeback).
module antares_muldiv_ctrl #(
    parameter logic [31:0] DBZ_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_mult,
    input  logic        op_multu,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mdu_stall,
    output logic        div_op_divs,
    output logic        div_op_divu,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic        div_stall
);

    typedef enum logic [2:0] {
        IDLE, MUL1, MUL2, DIV_START, DIV_WAIT, DRAIN
    } state_t;

    state_t      r_state;
    logic [31:0] r_hi, r_lo;
    logic [32:0] r_mul_a, r_mul_b;
    logic [63:0] r_prod;
    logic [31:0] r_dividend, r_divisor;
    logic        r_div_signed;
    logic [63:0] w_prod;
    logic        w_sign_a, w_sign_b;

    // The 66-bit two's-complement product is only ever observed through
    // bits [63:0], so a 64-bit multiply of the extended operands is exact.
    assign w_prod   = {{31{r_mul_a[32]}}, r_mul_a} * {{31{r_mul_b[32]}}, r_mul_b};
    assign w_sign_a = op_mult & rs_data[31];
    assign w_sign_b = op_mult & rt_data[31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_hi         <= '0;
            r_lo         <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_prod       <= '0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_div_signed <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!flush) begin
                        if (op_div || op_divu) begin
                            if (rt_data == '0) begin
                                r_hi <= rs_data;
                                r_lo <= DBZ_LO;
                            end else begin
                                r_dividend   <= rs_data;
                                r_divisor    <= rt_data;
                                r_div_signed <= op_div;
                                r_state      <= DIV_START;
                            end
                        end else if (op_mult || op_multu) begin
                            r_mul_a <= {w_sign_a, rs_data};
                            r_mul_b <= {w_sign_b, rt_data};
                            r_state <= MUL1;
                        end else if (op_mthi) begin
                            r_hi <= rs_data;
                        end else if (op_mtlo) begin
                            r_lo <= rs_data;
                        end
                    end
                end
                MUL1: begin
                    r_prod  <= w_prod;
                    r_state <= flush ? IDLE : MUL2;
                end
                MUL2: begin
                    if (!flush) begin
                        r_hi <= r_prod[63:32];
                        r_lo <= r_prod[31:0];
                    end
                    r_state <= IDLE;
                end
                DIV_START: r_state <= flush ? IDLE : DIV_WAIT;
                DIV_WAIT: begin
                    if (flush) begin
                        r_state <= DRAIN;
                    end else if (!div_stall) begin
                        r_lo    <= div_quotient;
                        r_hi    <= div_remainder;
                        r_state <= IDLE;
                    end
                end
                // Divider cannot be aborted; let it finish and discard the result.
                DRAIN: if (!div_stall) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hi           = r_hi;
    assign lo           = r_lo;
    assign mdu_stall    = (r_state != IDLE);
    assign div_op_divs  = (r_state == DIV_START) &&  r_div_signed && !flush;
    assign div_op_divu  = (r_state == DIV_START) && !r_div_signed && !flush;
    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;

endmodule

// File: doc/antares_muldiv_ctrl.md
Name: antares_muldiv_ctrl

Overview:
Multiply/divide control unit between the EX stage and the multi-cycle divider. It decodes MDU strobes and owns the architectural HI/LO registers. It runs a 2-cycle pipelined 32x32 multiplier and sequences divide operations: it issues the one-cycle start pulse, tracks the divider busy flag, and writes quotient/remainder back into LO/HI. It also raises the pipeline stall, handles divide-by-zero locally, and cancels in-flight work on flush.

Parameters:
DBZ_LO, 32'hFFFF_FFFF, value written to LO on divide-by-zero (HI receives the dividend)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
op_mult  in  1  signed multiply strobe, 1-cycle
op_multu  in  1  unsigned multiply strobe
op_div  in  1  signed divide strobe
op_divu  in  1  unsigned divide strobe
op_mthi  in  1  write rs_data to HI
op_mtlo  in  1  write rs_data to LO
flush  in  1  cancel current/pending MDU operation (pipeline exception)
rs_data  in  32  operand A / dividend / MTHI-MTLO data
rt_data  in  32  operand B / divisor
hi  out  32  HI register
lo  out  32  LO register
mdu_stall  out  1  1 whenever state != IDLE
div_op_divs  out  1  signed start pulse to divider
div_op_divu  out  1  unsigned start pulse to divider
div_dividend  out  32  latched dividend to divider
div_divisor  out  32  latched divisor to divider
div_quotient  in  32  divider quotient
div_remainder  in  32  divider remainder
div_stall  in  1  divider busy

Behaviour:
- Reset (rst=0, async): state=IDLE; hi=lo=0; operand latches=0; div_op_*=0; mdu_stall=0. Reset mid-operation drops all work; HI/LO read 0.
- States: IDLE, MUL1, MUL2, DIV_START, DIV_WAIT, DRAIN.
- Strobes are sampled only in IDLE; strobes in any other state are ignored (the pipeline holds them under mdu_stall).
- Priority when several strobes are high: div > divu > mult > multu > mthi > mtlo.
- flush=1 in IDLE blocks all strobes that cycle.
- MTHI/MTLO: in IDLE, register written at the edge; visible next cycle; no stall.
- MULT/MULTU (strobe in cycle N):
  - Operands are latched as 33-bit values: sign-extended for MULT, zero-extended for MULTU. State -> MUL1.
  - N+1 (MUL1): 66-bit product registered. State -> MUL2.
  - N+2 (MUL2): {hi,lo} <= product[63:0]. State -> IDLE.
  - Result visible and mdu_stall=0 at N+3.
- DIV/DIVU (strobe in cycle N):
  - rt_data==0: no divider start; hi<=rs_data, lo<=DBZ_LO at that edge; state stays IDLE; no stall.
  - Otherwise: rs/rt latched onto div_dividend/div_divisor; state -> DIV_START.
  - N+1 (DIV_START): div_op_divs (DIV) or div_op_divu (DIVU) = 1 for exactly this cycle, combinationally gated by !flush. State -> DIV_WAIT.
  - DIV_WAIT: wait while div_stall=1. The first cycle where div_stall=0: lo<=div_quotient, hi<=div_remainder, state -> IDLE.
  - With the 32-iteration divider: div_stall is high N+2..N+33, capture occurs at the end of N+34, and results are visible with mdu_stall=0 at N+35.
- Start pulses are never asserted outside DIV_START. At most one div_op_* is high in any cycle.
- Flush:
  - MUL1/MUL2 -> IDLE, no HI/LO write.
  - DIV_START -> IDLE, start pulse suppressed.
  - DIV_WAIT -> DRAIN.
  - DRAIN: mdu_stall=1; wait for div_stall=0, then IDLE with no HI/LO write. flush is ignored in DRAIN.
- HI/LO change only at the following points:
  - MTHI/MTLO edge.
  - Divide-by-zero edge.
  - MUL2 exit.
  - DIV_WAIT capture.
- Arithmetic: product is two's-complement 66-bit; only bits [63:0] are kept. Divider outputs are taken as-is (sign correction is done by the divider).

Test Plan:
- Reset then MTHI 0x1234_5678, MTLO 0xDEAD_BEEF -> next cycle hi=0x12345678, lo=0xDEADBEEF; mdu_stall never 1.
- MULT rs=0xFFFF_FFFE (-2), rt=3 -> mdu_stall high 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 with behavioural 32-cycle divider model -> one div_op_divs pulse at N+1; lo=0xFFFFFFFD, hi=0xFFFFFFFF visible at N+35; mdu_stall high N+1..N+34.
- DIVU rs=100, rt=0 -> no div_op pulse; next cycle hi=100, lo=0xFFFFFFFF; mdu_stall stays 0.
- DIVU 100/7 with flush asserted at N+5 -> state DRAIN until div_stall falls; hi/lo unchanged from prior values. A following MULT 5*6 then gives lo=30, hi=0.
- Simultaneous op_div and op_mult with rs=10, rt=3 -> divide performed (lo=3, hi=1). Asserting rst low at N+10 of a divide -> hi=lo=0 and mdu_stall=0 immediately.
